cla_seq_adder_ctrl: RTL and testbench
=====================================

Name: cla_seq_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition by time-multiplexing one external 4-bit CLA slice (a, b, c_in -> sum, c_out), one nibble per clock, LSB nibble first.
Sits between a requester (start/done handshake) and the shared CLA datapath.
Chains the carry between nibbles and reports sum, carry-out and signed overflow.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, number of nibble passes (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op_a  in  WIDTH  operand A; captured on the accepting edge
op_b  in  WIDTH  operand B; captured on the accepting edge
c_in  in  1  carry-in; captured on the accepting edge
busy  out  1  high in RUN
done  out  1  one-cycle pulse in FINISH
result  out  WIDTH  sum
c_out  out  1  carry out of the MSB
overflow  out  1  two's-complement overflow
cla_a  out  4  nibble of A to the CLA
cla_b  out  4  nibble of B to the CLA
cla_c_in  out  1  chained carry to the CLA
cla_sum  in  4  CLA sum
cla_c_out  in  1  CLA carry out

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, idx=0, carry=0, busy=0, done=0, result=0, c_out=0, overflow=0, A/B capture registers=0.
- States:
  - IDLE: wait for start; start=1 at edge E0 captures op_a, op_b, c_in (carry<=c_in), sets idx=0, goes to RUN.
  - RUN: busy=1.
    - Combinational drive: cla_a=A[4*idx+:4], cla_b=B[4*idx+:4], cla_c_in=carry.
    - Each edge: result[4*idx+:4]<=cla_sum, carry<=cla_c_out, idx<=idx+1.
    - At idx=NIB-1 the same edge also loads c_out<=cla_c_out and overflow<=A[W-1]^B[W-1]^cla_sum[3]^cla_c_out, then goes to FINISH.
  - FINISH: done=1, busy=0 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle following edge E0+NIB (NIB=4: edges E1..E4 process nibbles, done high after E4). Back-to-back throughput is one add per NIB+2 cycles.
- In IDLE and FINISH, cla_a=0, cla_b=0, cla_c_in=0.
- start while busy=1 or done=1 is ignored, not queued. Operand/c_in changes after E0 have no effect.
- result, c_out and overflow are valid from done onward. They hold until the next accepted start. During RUN, result nibbles update in place and are not valid.
- idx is wide enough for NIB-1 and never wraps past NIB-1.
- Wrap-around arithmetic: the sum is taken modulo 2^WIDTH, and c_out carries the bit WIDTH.
- rst_n low mid-RUN or in FINISH: immediate return to all reset values. No done pulse, partial result discarded.
- start=1 held continuously: a new add is accepted on the first IDLE edge after each FINISH.

Test Plan:
- WIDTH=16, op_a=0x0000, op_b=0x0000, c_in=0 -> done 4 cycles after accept; result=0x0000, c_out=0, overflow=0.
- op_a=0xFFFF, op_b=0x0000, c_in=1 -> result=0x0000, c_out=1, overflow=0. Check cla_c_in=1 on every nibble pass.
- op_a=0xAAAA, op_b=0x5555, c_in=0 -> result=0xFFFF, c_out=0. Then op_a=0x7FFF, op_b=0x0001 -> result=0x8000, overflow=1, c_out=0.
- op_a=0xFFFF, op_b=0xFFFF, c_in=1 -> result=0xFFFF, c_out=1, overflow=0.
- Pulse start again at RUN cycle 2 with different operands -> ignored; first result unchanged, exactly one done pulse.
- Drop rst_n for one cycle during RUN idx=2 -> busy=0, result=0, no done. A following start with 0x1234+0x0001 -> result=0x1235.

Source files
------------

// File: rtl/cla_seq_adder_ctrl.sv
// Sequencer that runs a WIDTH-bit add through one shared 4-bit CLA slice,
// one nibble per clock LSB first, chaining carry and reporting overflow.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_c_in,
  input  logic [3:0]       cla_sum,
  input  logic             cla_c_out
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic [IW-1:0]    idx_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             c_out_r;
  logic             overflow_r;
  logic             accept_s;
  logic             last_s;

  assign accept_s = (state_r == ST_IDLE) && start;
  assign last_s   = (state_r == ST_RUN) && (idx_r == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; FINISH always lasts exactly one cycle
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) begin
          state_s = ST_FINISH;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_RUN);
      done_r <= (state_s == ST_FINISH);
    end
  end

  // Operand capture, nibble index, carry chain and result assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      result_r   <= '0;
      idx_r      <= '0;
      carry_r    <= 1'b0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      a_r     <= op_a;
      b_r     <= op_b;
      carry_r <= c_in;
      idx_r   <= '0;
    end else if (state_r == ST_RUN) begin
      for (int n = 0; n < NIB; n++) begin
        if (idx_r == IW'(n)) begin
          result_r[4*n +: 4] <= cla_sum;
        end
      end
      carry_r <= cla_c_out;
      // Index parks on the last nibble instead of wrapping
      if (last_s) begin
        c_out_r    <= cla_c_out;
        overflow_r <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ cla_sum[3] ^ cla_c_out;
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end
  end

  // Slice drive: current nibble in RUN, quiet zeros otherwise
  always_comb begin
    cla_a    = 4'b0000;
    cla_b    = 4'b0000;
    cla_c_in = 1'b0;
    if (state_r == ST_RUN) begin
      cla_a    = 4'(a_r >> {idx_r, 2'b00});
      cla_b    = 4'(b_r >> {idx_r, 2'b00});
      cla_c_in = carry_r;
    end else begin
      cla_a    = 4'b0000;
      cla_b    = 4'b0000;
      cla_c_in = 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign c_out    = c_out_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for cla_seq_adder_ctrl: directed corner cases plus random
// adds, checked against plain-arithmetic sums with an attached CLA model.
module tb_cla_seq_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out, overflow, cla_c_in, cla_c_out;
  logic [W-1:0] result;
  logic [3:0]   cla_a, cla_b, cla_sum;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           dcyc;
  } exp_t;

  exp_t sb_q[$];

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .c_in(c_in), .busy(busy), .done(done), .result(result), .c_out(c_out),
    .overflow(overflow), .cla_a(cla_a), .cla_b(cla_b), .cla_c_in(cla_c_in),
    .cla_sum(cla_sum), .cla_c_out(cla_c_out)
  );

  // External 4-bit adder slice
  assign {cla_c_out, cla_sum} = 5'(cla_a) + 5'(cla_b) + 5'(cla_c_in);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input int dc);
    exp_t   e;
    longint s;
    s      = longint'(a) + longint'(b) + longint'(ci);
    e.res  = W'(s);
    e.co   = ((s >> W) & 64'd1) != 64'd0;
    e.ov   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    e.dcyc = dc;
    return e;
  endfunction

  function automatic longint carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input int i);
    longint m;
    m = (64'd1 << (4 * i)) - 64'd1;
    return ((longint'(a) & m) + (longint'(b) & m) + longint'(ci)) >> (4 * i);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending add (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", longint'(result), longint'(e.res));
        chk("c_out", longint'(c_out), longint'(e.co));
        chk("overflow", longint'(overflow), longint'(e.ov));
        chk("done_cycle", longint'(cyc), longint'(e.dcyc));
        chk("busy_at_done", longint'(busy), 64'd0);
        chk("cla_quiet_at_done", longint'({cla_a, cla_b, cla_c_in}), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", longint'(n >= 50), 64'd0);
  endtask

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input bit glitch);
    wait_idle();
    @(negedge clk);
    op_a = a; op_b = b; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb_q.push_back(model(a, b, ci, cyc + NIB));
    op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom);
    for (int i = 0; i < NIB; i++) begin
      @(negedge clk);
      chk("busy_run", longint'(busy), 64'd1);
      chk("cla_a", longint'(cla_a), (longint'(a) >> (4 * i)) & 64'hF);
      chk("cla_b", longint'(cla_b), (longint'(b) >> (4 * i)) & 64'hF);
      chk("cla_c_in", longint'(cla_c_in), carry_into(a, b, ci, i));
      if (glitch && i == 1) begin
        start = 1'b1;
        op_a = W'($urandom); op_b = W'($urandom);
      end
      if (glitch && i == 2) start = 1'b0;
    end
  endtask

  task automatic hold_start(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input int n);
    int c0;
    wait_idle();
    @(negedge clk);
    op_a = a; op_b = b; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int k = 0; k < n; k++) sb_q.push_back(model(a, b, ci, c0 + k * (NIB + 2) + NIB));
    repeat ((n - 1) * (NIB + 2)) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic reset_mid_run();
    wait_idle();
    @(negedge clk);
    op_a = 16'h4321; op_b = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", longint'(busy), 64'd0);
    chk("rst_done", longint'(done), 64'd0);
    chk("rst_result", longint'(result), 64'd0);
    chk("rst_flags", longint'({c_out, overflow}), 64'd0);
    chk("rst_cla", longint'({cla_a, cla_b, cla_c_in}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy_done", longint'({busy, done}), 64'd0);
    chk("reset_result", longint'(result), 64'd0);
    chk("reset_flags", longint'({c_out, overflow}), 64'd0);
    chk("reset_cla", longint'({cla_a, cla_b, cla_c_in}), 64'd0);
    rst_n = 1'b1;

    do_add(16'h0000, 16'h0000, 1'b0, 1'b0);
    do_add(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    do_add(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    do_add(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    do_add(16'h8000, 16'h8000, 1'b0, 1'b0);
    do_add(16'h1357, 16'h2468, 1'b1, 1'b1);
    reset_mid_run();
    do_add(16'h1234, 16'h0001, 1'b0, 1'b0);
    hold_start(16'h9ABC, 16'h6543, 1'b1, 3);
    for (int r = 0; r < 20; r++) begin
      do_add(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    end

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("drain_pending", longint'(sb_q.size()), 64'd0);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
